serial_dev: RTL and testbench
=============================

# serial_dev

Byte-wide serial console peripheral on the CPU's 16-bit data bus, downstream of the CPU's device-in/device-out (DI/DO) control bits. It exposes a data port and a status port at two device addresses. It buffers outgoing bytes in a TX FIFO and incoming bytes in an RX FIFO. It serialises and deserialises 8N1 frames on `tx`/`rx` at a fixed divisor of the system clock.

## Interface
- `CLK_DIV`, default 16: system clocks per serial bit; must be ≥4 and even.
- `FIFO_DEPTH`, default 8: entries per FIFO; power of two, ≥2.
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `addr` in 8: device address, held stable by the CPU while `di`/`do` is asserted.
- `bus_in` in 16: write data from the CPU bus.
- `di` in 1: device write strobe (CPU "device in"), one cycle per access.
- `do` in 1: device read strobe (CPU "device out"), one cycle per access.
- `bus_out` out 16: read data.
- `bus_oe` out 1: high when `bus_out` must drive the bus.
- `tx` out 1: serial transmit line, idle high.
- `rx` in 1: serial receive line, asynchronous.

## Operation
- Address map:
  - `0x00` DATA. A write pushes `bus_in[7:0]`. A read returns `{8'h00, rx_head}` and pops.
  - `0x01` STATUS, read-only.
  - Any other address: `bus_oe` = 0; writes are ignored.
- STATUS bits:
  - 0 `rx_avail`: RX FIFO not empty.
  - 1 `tx_full`: TX FIFO full.
  - 2 `rx_overrun`: sticky.
  - 3 `rx_frame_err`: sticky.
  - 4 `tx_idle`: TX FIFO empty and shifter idle.
  - Bits 15:5 read 0.
  - A STATUS read clears bits 2 and 3 at the end of that cycle; the read itself returns the pre-clear values.
- Write to DATA when TX FIFO is full: byte dropped, no flag set.
- Read of DATA when RX FIFO is empty: returns `0x0000`, no pop.
- `di` and `do` asserted together: illegal; `do` wins, the write is ignored.
- TX FSM states:
  - IDLE → START: when FIFO not empty; pop the FIFO and load the shifter.
  - START → DATA×8 (LSB first) → STOP.
  - STOP → IDLE, or STOP → START directly when the FIFO is not empty (back-to-back frames, no extra idle bit).
  - Each state lasts exactly `CLK_DIV` clocks.
- RX FSM states:
  - Input path: 2-flop synchroniser on `rx`.
  - IDLE → START on a synchronised falling edge.
  - At `CLK_DIV/2` the start bit is re-sampled. If high → IDLE (glitch); otherwise → DATA.
  - DATA samples every `CLK_DIV` clocks at mid-bit, 8 bits, LSB first, then STOP is sampled.
  - Stop bit high: push the byte. If the FIFO is full, discard the byte and set `rx_overrun`.
  - Stop bit low: discard the byte, set `rx_frame_err`, and wait for the line to go high before returning to IDLE.
- Simultaneous RX push and CPU pop in one cycle on a full FIFO: both succeed, no overrun.

## Timing
- Reset values:
  - `tx` = 1, `bus_out` = 0, `bus_oe` = 0.
  - Both FIFOs empty, both FSMs in IDLE, sticky flags 0, divider counters 0.
- Reset asserted mid-frame aborts immediately; `tx` is high on the cycle after reset.
- `bus_oe` and `bus_out` are combinational from `do` and `addr`, and valid in the same cycle as `do`. The pop and the flag clear take effect at the following edge.
- A write with `di` in cycle N is visible in the FIFO at N+1. From an idle, empty transmitter, `tx` falls at N+2.
- Frame length: `10*CLK_DIV` clocks.
- The last data bit is received at edge E; `rx_avail` reads 1 at `E + CLK_DIV` + 1 (after the stop sample).
- FIFO pointers are `log2(FIFO_DEPTH)+1` bits wide; full/empty come from MSB compare, and the pointers wrap modulo `2*FIFO_DEPTH`.

## Configuration
- `SERIAL_LOOPBACK_EN` defined:
  - Adds a CONTROL register at `0x02`. Bit 0 is `loopback`, read/write, reset value 0; other bits read 0.
  - With `loopback` = 1, the RX synchroniser input is the internal TX line and `tx` is held at 1.
- Undefined: address `0x02` behaves as unmapped and the `rx` pin always feeds RX.

## Structure
- Package `serial_pkg`:
  - Address constants `SER_DATA_ADDR`, `SER_STATUS_ADDR`, `SER_CTRL_ADDR`.
  - STATUS bit-index constants.
  - TX and RX FSM state enums.
- Sub-module `serial_fifo`, instantiated twice: parameterised width and depth, with push/pop/full/empty/head, and simultaneous push and pop allowed when full or empty.

## Test plan
- Reset, then write `0x0041` to DATA: `tx` falls 2 cycles later and the frame 0,1,0,0,0,0,0,1,0,1 follows at 16 clocks/bit (`CLK_DIV` = 16). STATUS bit 4 returns to 1 after 160 clocks.
- Drive `0x5A` serially on `rx`: STATUS reads `0x0001`, a DATA read returns `0x005A`, then STATUS reads `0x0010`.
- Write 10 bytes back-to-back with the TX line stalled behind the first frame: exactly 9 bytes are transmitted (1 in the shifter + 8 in the FIFO), the 10th is dropped, and `tx_full` is seen.
- Receive 9 frames without reading: STATUS = `0x0015`, DATA returns the first 8 bytes in order, and a second STATUS read shows bit 2 = 0.
- Send a frame with the stop bit low: no push, STATUS bit 3 = 1; a 1-clock low glitch on `rx` pushes nothing.
- With `SERIAL_LOOPBACK_EN`: write `0x0001` to `0x02`, then `0x00C3` to DATA: `tx` stays 1 and `0x00C3` is read back from DATA.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared constants and FSM state types for the serial console peripheral.
package serial_pkg;

  localparam logic [7:0] SER_DATA_ADDR   = 8'h00;
  localparam logic [7:0] SER_STATUS_ADDR = 8'h01;
  localparam logic [7:0] SER_CTRL_ADDR   = 8'h02;

  localparam int unsigned ST_RX_AVAIL     = 0;
  localparam int unsigned ST_TX_FULL      = 1;
  localparam int unsigned ST_RX_OVERRUN   = 2;
  localparam int unsigned ST_RX_FRAME_ERR = 3;
  localparam int unsigned ST_TX_IDLE      = 4;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/serial_dev_if.sv
// CPU device-bus signals seen by the serial peripheral (do_strobe is the CPU "device out" read strobe).
interface serial_dev_if;
  logic [7:0]  addr;
  logic [15:0] bus_in;
  logic        di;
  logic        do_strobe;
  logic [15:0] bus_out;
  logic        bus_oe;

  modport master (output addr, bus_in, di, do_strobe, input bus_out, bus_oe);
  modport slave  (input addr, bus_in, di, do_strobe, output bus_out, bus_oe);
endinterface

// File: rtl/serial_fifo.sv
// Synchronous FIFO with extra-MSB pointers; push and pop may coincide when full or empty.
module serial_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                   (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[IDX_W-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[IDX_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/serial_dev.sv
// Byte-wide 8N1 serial console on the CPU device bus: DATA/STATUS ports, TX and RX FIFOs.
// Optional SERIAL_LOOPBACK_EN adds a CONTROL register whose bit 0 routes TX into RX.
module serial_dev
  import serial_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  serial_dev_if.slave  bus,
  output logic         tx,
  input  logic         rx
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);

  logic rd_data, rd_status, wr_data;
  logic tx_full, tx_empty, tx_pop;
  logic rx_full, rx_empty, rx_push;
  logic [7:0] tx_head, rx_head;
  logic loopback, rx_src, tx_q;
  logic rx_overrun, rx_frame_err, set_overrun, set_frame_err;
  logic [15:0] status;
  logic unused_bus_hi;

  assign rd_data   = bus.do_strobe && (bus.addr == SER_DATA_ADDR);
  assign rd_status = bus.do_strobe && (bus.addr == SER_STATUS_ADDR);
  assign wr_data   = bus.di && !bus.do_strobe && (bus.addr == SER_DATA_ADDR);
  assign unused_bus_hi = ^bus.bus_in[15:8];

`ifdef SERIAL_LOOPBACK_EN
  always_ff @(posedge clk) begin
    if (reset) loopback <= 1'b0;
    else if (bus.di && !bus.do_strobe && (bus.addr == SER_CTRL_ADDR)) loopback <= bus.bus_in[0];
  end
`else
  assign loopback = 1'b0;
`endif

  assign tx     = loopback ? 1'b1 : tx_q;
  assign rx_src = loopback ? tx_q : rx;

  serial_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(wr_data), .push_data(bus.bus_in[7:0]),
    .pop(tx_pop), .head(tx_head), .full(tx_full), .empty(tx_empty)
  );

  // ---------------- transmitter ----------------
  tx_state_t        tx_state, tx_state_n;
  logic [CNT_W-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]       tx_bit, tx_bit_n;
  logic [7:0]       tx_shift, tx_shift_n;
  logic             tx_n, tx_end;

  assign tx_end = (tx_cnt == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_q     <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx_q     <= tx_n;
    end
  end

  // tx_n is the line level for the cycle that follows each transition.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_n       = tx_q;
    tx_pop     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_n = 1'b1;
        if (!tx_empty) begin
          tx_state_n = TX_START;
          tx_pop     = 1'b1;
          tx_shift_n = tx_head;
          tx_cnt_n   = '0;
          tx_n       = 1'b0;
        end
      end
      TX_START: begin
        if (tx_end) begin
          tx_state_n = TX_DATA;
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          tx_n       = tx_shift[0];
        end else begin
          tx_cnt_n = tx_cnt + CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (tx_end) begin
          tx_cnt_n = '0;
          if (tx_bit == 3'd7) begin
            tx_state_n = TX_STOP;
            tx_n       = 1'b1;
          end else begin
            tx_shift_n = {1'b0, tx_shift[7:1]};
            tx_bit_n   = tx_bit + 3'd1;
            tx_n       = tx_shift[1];
          end
        end else begin
          tx_cnt_n = tx_cnt + CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (tx_end) begin
          tx_cnt_n = '0;
          if (!tx_empty) begin
            tx_state_n = TX_START;
            tx_pop     = 1'b1;
            tx_shift_n = tx_head;
            tx_n       = 1'b0;
          end else begin
            tx_state_n = TX_IDLE;
            tx_n       = 1'b1;
          end
        end else begin
          tx_cnt_n = tx_cnt + CNT_W'(1);
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // ---------------- receiver ----------------
  rx_state_t        rx_state, rx_state_n;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]       rx_bit, rx_bit_n;
  logic [7:0]       rx_shift, rx_shift_n;
  logic             rx_s1, rx_s2, rx_prev, rx_mid, rx_end;

  assign rx_mid = (rx_cnt == CNT_W'(CLK_DIV / 2 - 1));
  assign rx_end = (rx_cnt == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1    <= rx_src;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  always_comb begin
    rx_state_n    = rx_state;
    rx_cnt_n      = rx_cnt;
    rx_bit_n      = rx_bit;
    rx_shift_n    = rx_shift;
    rx_push       = 1'b0;
    set_overrun   = 1'b0;
    set_frame_err = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_s2) begin
          rx_state_n = RX_START;
          rx_cnt_n   = '0;
        end
      end
      RX_START: begin
        if (rx_mid) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_n = rx_cnt + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_end) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_s2, rx_shift[7:1]};
          rx_bit_n   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
        end else begin
          rx_cnt_n = rx_cnt + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_end) begin
          rx_cnt_n = '0;
          if (rx_s2) begin
            rx_push     = 1'b1;
            set_overrun = rx_full && !rd_data;
            rx_state_n  = RX_IDLE;
          end else begin
            set_frame_err = 1'b1;
            rx_state_n    = RX_WAIT_HIGH;
          end
        end else begin
          rx_cnt_n = rx_cnt + CNT_W'(1);
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_s2) rx_state_n = RX_IDLE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  serial_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .push_data(rx_shift),
    .pop(rd_data), .head(rx_head), .full(rx_full), .empty(rx_empty)
  );

  // Sticky error flags; a new event in the clearing cycle is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_overrun   <= set_overrun   || (rx_overrun   && !rd_status);
      rx_frame_err <= set_frame_err || (rx_frame_err && !rd_status);
    end
  end

  always_comb begin
    status                  = '0;
    status[ST_RX_AVAIL]     = !rx_empty;
    status[ST_TX_FULL]      = tx_full;
    status[ST_RX_OVERRUN]   = rx_overrun;
    status[ST_RX_FRAME_ERR] = rx_frame_err;
    status[ST_TX_IDLE]      = tx_empty && (tx_state == TX_IDLE);
  end

  // Read mux is combinational so data is valid in the strobe cycle.
  always_comb begin
    bus.bus_out = '0;
    bus.bus_oe  = 1'b0;
    if (rd_data) begin
      bus.bus_oe  = 1'b1;
      bus.bus_out = {8'h00, (rx_empty ? 8'h00 : rx_head)};
    end else if (rd_status) begin
      bus.bus_oe  = 1'b1;
      bus.bus_out = status;
    end
`ifdef SERIAL_LOOPBACK_EN
    else if (bus.do_strobe && (bus.addr == SER_CTRL_ADDR)) begin
      bus.bus_oe  = 1'b1;
      bus.bus_out = {15'h0000, loopback};
    end
`endif
  end

endmodule

// File: tb/tb_serial_dev.sv
// Directed bench for serial_dev with expected-byte queues for the TX and RX paths.
module tb_serial_dev;
  import serial_pkg::*;

  localparam int unsigned CLK_DIV = 16;

  logic clk = 1'b0;
  logic reset;
  logic tx;
  logic rx;

  serial_dev_if sif ();

  serial_dev #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .bus(sif), .tx(tx), .rx(rx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [15:0] d);
    sif.addr   = a;
    sif.bus_in = d;
    sif.di     = 1'b1;
    step();
    sif.di     = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [7:0] a,
                            input logic [15:0] exp, input logic exp_oe);
    logic [15:0] d;
    logic oe;
    sif.addr      = a;
    sif.do_strobe = 1'b1;
    #1;
    d  = sif.bus_out;
    oe = sif.bus_oe;
    step();
    sif.do_strobe = 1'b0;
    check(tag, 32'({oe, d}), 32'({exp_oe, exp}));
  endtask

  task automatic rx_data_check(input string tag);
    logic [7:0] e;
    e = (rx_exp.size() > 0) ? rx_exp.pop_front() : 8'hxx;
    read_check(tag, SER_DATA_ADDR, {8'h00, e}, 1'b1);
  endtask

  task automatic wait_tx_low(input int budget, output int waited, output bit found);
    waited = 0;
    found  = 1'b0;
    while (waited < budget && !found) begin
      if (tx === 1'b0) found = 1'b1;
      else begin
        step();
        waited++;
      end
    end
  endtask

  // Samples 10 bits; first sample after first_delay cycles, then every CLK_DIV.
  task automatic capture_frame(input int first_delay, output logic [9:0] bits);
    steps(first_delay);
    bits[0] = tx;
    for (int i = 1; i < 10; i++) begin
      steps(CLK_DIV);
      bits[i] = tx;
    end
  endtask

  task automatic tx_frame_check(input string tag, input bit aligned, input int first_delay);
    int w;
    bit f;
    logic [9:0] bits;
    logic [7:0] e;
    f = 1'b1;
    if (!aligned) begin
      wait_tx_low(400, w, f);
      check({tag, "_start"}, 32'(f), 32'd1);
    end
    if (f) begin
      capture_frame(first_delay, bits);
      e = (tx_exp.size() > 0) ? tx_exp.pop_front() : 8'hxx;
      check(tag, 32'(bits), 32'({1'b1, e, 1'b0}));
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    steps(CLK_DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      steps(CLK_DIV);
    end
    rx = stop_bit;
    steps(CLK_DIV);
    rx = 1'b1;
  endtask

  initial begin
    int w;
    bit f;
    int bad;
    logic [15:0] d;
    logic oe;

    reset = 1'b1;
    rx = 1'b1;
    sif.addr = '0;
    sif.bus_in = '0;
    sif.di = 1'b0;
    sif.do_strobe = 1'b0;
    steps(3);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_oe_out", 32'({sif.bus_oe, sif.bus_out}), 32'd0);
    reset = 1'b0;
    step();
    read_check("status_after_reset", SER_STATUS_ADDR, 16'h0010, 1'b1);

    // Single frame 0x41.
    cpu_write(SER_DATA_ADDR, 16'h0041);
    tx_exp.push_back(8'h41);
    check("tx_high_cycle_after_write", 32'(tx), 32'd1);
    wait_tx_low(50, w, f);
    check("tx_fall_latency", 32'(w), 32'd1);
    tx_frame_check("frame_41", 1'b1, 8);
    steps(7);
    read_check("status_tx_busy", SER_STATUS_ADDR, 16'h0000, 1'b1);
    read_check("status_tx_idle", SER_STATUS_ADDR, 16'h0010, 1'b1);

    // Receive 0x5A.
    send_rx(8'h5A, 1'b1);
    rx_exp.push_back(8'h5A);
    read_check("status_rx_avail", SER_STATUS_ADDR, 16'h0011, 1'b1);
    rx_data_check("rx_data_5a");
    read_check("status_rx_drained", SER_STATUS_ADDR, 16'h0010, 1'b1);

    // Ten back-to-back writes: shifter + 8 FIFO entries, tenth dropped.
    for (int i = 0; i < 10; i++) begin
      cpu_write(SER_DATA_ADDR, 16'(8'h10 + 8'(i)));
      if (i < 9) tx_exp.push_back(8'h10 + 8'(i));
    end
    read_check("status_tx_full", SER_STATUS_ADDR, 16'h0002, 1'b1);
    tx_frame_check("burst_frame0", 1'b1, 0);
    for (int i = 1; i < 9; i++) tx_frame_check($sformatf("burst_frame%0d", i), 1'b0, 8);
    wait_tx_low(300, w, f);
    check("no_tenth_frame", 32'(f), 32'd0);
    check("tx_queue_drained", 32'(tx_exp.size()), 32'd0);

    // Nine frames without reading: overrun on the ninth.
    for (int i = 0; i < 9; i++) begin
      send_rx(8'hA0 + 8'(i), 1'b1);
      if (i < 8) rx_exp.push_back(8'hA0 + 8'(i));
      steps(2);
    end
    read_check("status_overrun", SER_STATUS_ADDR, 16'h0015, 1'b1);
    for (int i = 0; i < 8; i++) rx_data_check($sformatf("rx_fifo_%0d", i));
    read_check("status_overrun_cleared", SER_STATUS_ADDR, 16'h0010, 1'b1);
    read_check("data_read_empty", SER_DATA_ADDR, 16'h0000, 1'b1);

    // Framing error, then a one-cycle glitch.
    send_rx(8'h33, 1'b0);
    steps(5);
    read_check("status_frame_err", SER_STATUS_ADDR, 16'h0018, 1'b1);
    read_check("status_frame_err_cleared", SER_STATUS_ADDR, 16'h0010, 1'b1);
    rx = 1'b0;
    step();
    rx = 1'b1;
    steps(200);
    read_check("status_after_glitch", SER_STATUS_ADDR, 16'h0010, 1'b1);

    // Unmapped address and di/do collision.
    read_check("unmapped_read", 8'h05, 16'h0000, 1'b0);
    cpu_write(8'h05, 16'h00AB);
    sif.addr = SER_DATA_ADDR;
    sif.bus_in = 16'h0077;
    sif.di = 1'b1;
    sif.do_strobe = 1'b1;
    #1;
    d  = sif.bus_out;
    oe = sif.bus_oe;
    step();
    sif.di = 1'b0;
    sif.do_strobe = 1'b0;
    check("collision_read", 32'({oe, d}), 32'h0001_0000);
    steps(3);
    read_check("no_write_on_collision", SER_STATUS_ADDR, 16'h0010, 1'b1);

    // Reset in the middle of a frame.
    cpu_write(SER_DATA_ADDR, 16'h0055);
    steps(40);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("tx_high_after_midframe_reset", 32'(tx), 32'd1);
    read_check("status_after_midframe_reset", SER_STATUS_ADDR, 16'h0010, 1'b1);
    wait_tx_low(200, w, f);
    check("no_frame_after_reset", 32'(f), 32'd0);

`ifdef SERIAL_LOOPBACK_EN
    cpu_write(SER_CTRL_ADDR, 16'h0001);
    read_check("ctrl_readback", SER_CTRL_ADDR, 16'h0001, 1'b1);
    cpu_write(SER_DATA_ADDR, 16'h00C3);
    rx_exp.push_back(8'hC3);
    bad = 0;
    for (int i = 0; i < 220; i++) begin
      step();
      if (tx !== 1'b1) bad++;
    end
    check("loopback_tx_held_high", 32'(bad), 32'd0);
    rx_data_check("loopback_data");
`else
    bad = 0;
    read_check("ctrl_unmapped", SER_CTRL_ADDR, 16'h0000, 1'b0);
    check("ctrl_unmapped_bad", 32'(bad), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
